// File: rtl/half_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : half_period_meter
//  Purpose  : Measures the clk-cycle interval between edges of an external
//             square wave and reports it as the equivalent divider max_count.
//  Revision : 1.0
// ============================================================================
module half_period_meter #(
   parameter int N           = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         sig_in,
   input  logic [N-1:0] timeout,
   output logic [N-1:0] meas_count,
   output logic         meas_valid,
   output logic         meas_timeout,
   output logic         saturated,
   output logic         level
);

   localparam logic [N-1:0] C_CNT_MAX = '1;
   localparam logic [N-1:0] C_ONE     = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_enable_d;
   logic [N-1:0]           r_cnt;

   logic                   w_sync;
   logic                   w_edge;
   logic                   w_enable_rise;
   logic                   w_timeout_hit;
   logic [N-1:0]           w_cnt_inc;

   assign w_sync        = r_sync[SYNC_STAGES-1];
   assign w_edge        = w_sync ^ r_prev;
   assign w_enable_rise = enable & ~r_enable_d;
   assign w_timeout_hit = (timeout != '0) && (r_cnt == timeout);
   assign w_cnt_inc     = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_ONE;
   assign level         = w_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync       <= '0;
         r_prev       <= 1'b0;
         r_enable_d   <= 1'b0;
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         meas_count   <= '0;
         meas_valid   <= 1'b0;
         meas_timeout <= 1'b0;
         saturated    <= 1'b0;
      end else begin
         r_sync       <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_prev       <= w_sync;
         r_enable_d   <= enable;
         meas_valid   <= 1'b0;
         meas_timeout <= 1'b0;

         // A rising enable can only happen from IDLE, so it never races a saturation set
         if (w_enable_rise)
            saturated <= 1'b0;

         if (!enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cnt   <= '0;
                  r_state <= S_ARM;
               end
               S_ARM: begin
                  if (w_edge) begin
                     r_cnt   <= C_ONE;
                     r_state <= S_MEASURE;
                  end
               end
               S_MEASURE: begin
                  // An edge takes priority over a coincident timeout
                  if (w_edge) begin
                     meas_count <= r_cnt;
                     meas_valid <= 1'b1;
                     r_cnt      <= C_ONE;
                  end else if (w_timeout_hit) begin
                     meas_timeout <= 1'b1;
                     meas_count   <= '0;
                     r_cnt        <= '0;
                     r_state      <= S_ARM;
                  end else begin
                     r_cnt <= w_cnt_inc;
                     if (w_cnt_inc == C_CNT_MAX)
                        saturated <= 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_half_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for half_period_meter: random edge intervals scored against an
// event-level model of intervals, timeouts and saturation.
module tb_half_period_meter;

   localparam int N           = 8;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_MAX     = (1 << N) - 1;

   logic         clk     = 1'b0;
   logic         reset   = 1'b0;
   logic         enable  = 1'b0;
   logic         sig_in  = 1'b0;
   logic [N-1:0] timeout = '0;
   logic [N-1:0] meas_count;
   logic         meas_valid;
   logic         meas_timeout;
   logic         saturated;
   logic         level;

   half_period_meter #(.N(N), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sig_in       (sig_in),
      .timeout      (timeout),
      .meas_count   (meas_count),
      .meas_valid   (meas_valid),
      .meas_timeout (meas_timeout),
      .saturated    (saturated),
      .level        (level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int is_to;
      int value;
      int t;
   } ev_t;

   ev_t act_q[$];
   ev_t exp_q[$];

   always @(negedge clk) begin
      if (reset) begin
         if (meas_valid)   act_q.push_back('{0, int'(meas_count), cyc});
         if (meas_timeout) act_q.push_back('{1, int'(meas_count), cyc});
      end
   end

   // Event model: times are sig_in toggle cycles; the DUT adds a constant delay
   bit m_meas  = 1'b0;
   int m_last  = 0;
   int m_tmo   = 0;
   bit m_sat   = 1'b0;
   int m_count = 0;

   function automatic void model_edge(input int t);
      int iv;
      if (!m_meas) begin
         m_meas = 1'b1;
         m_last = t;
      end else begin
         iv = t - m_last;
         if (m_tmo != 0 && iv > m_tmo) begin
            exp_q.push_back('{1, 0, m_last + m_tmo});
            m_count = 0;
         end else begin
            if (iv >= CNT_MAX) m_sat = 1'b1;
            m_count = (iv > CNT_MAX) ? CNT_MAX : iv;
            exp_q.push_back('{0, m_count, t});
         end
         m_last = t;
      end
   endfunction

   function automatic void model_flush(input int now);
      if (m_meas && m_tmo != 0 && (now - m_last) > m_tmo + SYNC_STAGES + 2) begin
         exp_q.push_back('{1, 0, m_last + m_tmo});
         m_count = 0;
         m_meas  = 1'b0;
      end
   endfunction

   function automatic bit model_sat(input int now);
      return m_sat || (m_meas && m_tmo == 0 && (now - m_last) >= CNT_MAX + SYNC_STAGES + 2);
   endfunction

   int prev_act_t = -1;
   int prev_exp_t = -1;

   task automatic compare_events(input string tag);
      ev_t a;
      ev_t e;
      check({tag, ":n_events"}, act_q.size(), exp_q.size());
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front();
         e = exp_q.pop_front();
         check({tag, ":kind"}, a.is_to, e.is_to);
         check({tag, ":count"}, a.value, e.value);
         if (prev_act_t >= 0)
            check({tag, ":gap"}, a.t - prev_act_t, e.t - prev_exp_t);
         prev_act_t = a.t;
         prev_exp_t = e.t;
      end
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic toggle();
      sig_in = ~sig_in;
      if (enable) model_edge(cyc);
   endtask

   task automatic enable_on();
      enable = 1'b1;
      m_sat  = 1'b0;
   endtask

   task automatic enable_off();
      enable = 1'b0;
      m_meas = 1'b0;
   endtask

   task automatic set_timeout(input int v);
      enable_off();
      tick(2);
      timeout = N'(v);
      m_tmo   = v;
      enable_on();
      tick(4);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ":count"}, meas_count, 0);
      check({tag, ":valid"}, meas_valid, 0);
      check({tag, ":timeout"}, meas_timeout, 0);
      check({tag, ":sat"}, saturated, 0);
      check({tag, ":level"}, level, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tick(3);
      check_outputs_zero("reset");
      reset = 1'b1;
      tick(2);
      enable_on();
      tick(4);

      // Steady toggle every 5, then a transitional 6, then steady 8
      for (int i = 0; i < 8; i++) begin tick(5); toggle(); end
      tick(6); toggle();
      for (int i = 0; i < 6; i++) begin tick(8); toggle(); end
      tick(10);
      compare_events("period");
      check("period:last_count", meas_count, m_count);
      check("period:level", level, sig_in);

      // Timeout 100 with random intervals straddling it
      set_timeout(100);
      repeat (12) begin tick($urandom_range(1, 120)); toggle(); end
      tick(130);
      model_flush(cyc);
      compare_events("tmo100");
      check("tmo100:count_zero", meas_count, m_count);
      tick(20); toggle();
      tick(30); toggle();
      tick(10);
      compare_events("rearm");
      check("rearm:count", meas_count, m_count);
      tick(110);
      model_flush(cyc);
      compare_events("tmo100b");

      // Timeout equal to the period: edge must win
      set_timeout(5);
      for (int i = 0; i < 8; i++) begin tick(5); toggle(); end
      repeat (10) begin tick($urandom_range(1, 8)); toggle(); end
      tick(20);
      model_flush(cyc);
      compare_events("tmo5");

      // Saturation with the timeout disabled
      set_timeout(0);
      toggle();
      tick(270);
      compare_events("hold");
      check("hold:sat", saturated, model_sat(cyc));
      check("hold:count", meas_count, m_count);
      toggle();
      tick(6);
      compare_events("sat_edge");
      check("sat_edge:count", meas_count, m_count);

      // Enable dropped for 3 cycles mid-interval
      tick(7); toggle();
      tick(6);
      enable_off();
      tick(3);
      enable_on();
      tick(2);
      check("endrop:sat", saturated, model_sat(cyc));
      tick(4); toggle();
      tick(9); toggle();
      tick(8);
      compare_events("endrop");
      check("endrop:count", meas_count, m_count);

      // Asynchronous reset in the middle of a saturated measurement
      tick(5); toggle();
      tick(270);
      compare_events("pre_reset");
      check("pre_reset:sat", saturated, model_sat(cyc));
      @(posedge clk);
      #3;
      reset  = 1'b0;
      sig_in = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      act_q.delete();
      exp_q.delete();
      m_meas     = 1'b0;
      m_count    = 0;
      m_sat      = 1'b0;
      prev_act_t = -1;
      prev_exp_t = -1;
      tick(2);
      reset = 1'b1;
      tick(4);
      repeat (3) begin tick($urandom_range(2, 40)); toggle(); end
      tick(10);
      compare_events("post_reset");
      check("post_reset:count", meas_count, m_count);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
